sm_accum_initiator: RTL
=======================

Name: sm_accum_initiator

Overview:
- Requester side of the sign-magnitude adder handshake (cs_add / rdy_add / x / y / sum) used in the GRU datapath.
- Accepts a stream of 16-bit sign-magnitude operands on a valid/ready input and accumulates N_TERMS of them.
- Issues one add request per operand after the first, waits for the adder's completion, and emits the final sum with a one-cycle valid pulse.
- Sits between the GRU gate operand buffers and an external adder instance; it contains no adder of its own.

Parameters:
- N_TERMS, 8, number of operands summed per start (legal range 1..2^CNT_W-1).
- CNT_W, 4, width of the term counter.
- TIMEOUT, 15, maximum cycles spent waiting on rdy_add in any single wait state before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin an accumulation; sampled only in IDLE.
- in_valid  in  1  operand available.
- in_data  in  16  operand, sign-magnitude: bit15 sign, [14:0] magnitude.
- in_ready  out  1  operand accepted this cycle when in_valid & in_ready.
- cs_add  out  1  add request to adder, registered, one-cycle pulse.
- x  out  16  adder operand 1 (running accumulator), registered.
- y  out  16  adder operand 2 (new operand), registered.
- sum  in  16  adder result, sign-magnitude.
- rdy_add  in  1  adder ready/complete.
- acc_out  out  16  final accumulated value, sign-magnitude.
- acc_valid  out  1  one-cycle pulse when acc_out is updated.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  sticky abort flag.

Behaviour:
- Reset values: in_ready=0, cs_add=0, x=0, y=0, acc_out=0, acc_valid=0, busy=0, err_timeout=0; FSM goes to IDLE; counter=0; internal acc=0.
- Reset mid-operation: the next edge forces cs_add low and all outputs to their reset values. A pending adder transaction is abandoned.
- Adder protocol (decided):
  - rdy_add is high while the adder is idle.
  - One cs_add cycle launches an add.
  - rdy_add drops and then rises again with sum valid on that rising cycle.
  - x and y must stay stable from the cs_add cycle through the capture cycle.
- IDLE: when start=1, clear err_timeout and counter, and go to LOAD. start in any other state is ignored.
- LOAD: in_ready=1. On handshake, acc<=in_data and count<=1.
  - If N_TERMS==1, go to DONE.
  - Otherwise go to FETCH.
- FETCH: in_ready=1. On handshake, x<=acc, y<=in_data, and go to REQ.
- REQ: cs_add=1 for exactly this cycle, then go to WAIT_LO. REQ is entered only when rdy_add=1; otherwise the FSM stays in REQ with cs_add low until rdy_add=1.
- WAIT_LO: wait for rdy_add=0, then go to WAIT_HI. A high rdy_add in this state is not completion.
- WAIT_HI: wait for rdy_add=1. On that cycle, acc<=sum and count<=count+1.
  - If count+1==N_TERMS, go to DONE.
  - Otherwise go to FETCH.
- DONE (one cycle):
  - acc_out<=acc, with negative zero (16'h8000) normalized to 16'h0000.
  - acc_valid=1 for this cycle only.
  - Go to IDLE.
- Timeout: a wait counter resets on entry to WAIT_LO and to WAIT_HI. If it reaches TIMEOUT:
  - set err_timeout=1;
  - go to IDLE;
  - acc_out is unchanged and acc_valid is not pulsed.
- in_ready is deasserted in REQ, WAIT_LO, WAIT_HI, DONE and IDLE. No operand is consumed outside LOAD and FETCH.
- Latency with a 3-cycle adder, operands always valid:
  - 1 cycle for LOAD.
  - 5 cycles per additional term (FETCH, REQ, WAIT_LO, 2x WAIT_HI).
  - 1 cycle for DONE.
- No overflow detection. Magnitude wrap is the adder's responsibility.

Test Plan:
- N_TERMS=4, operands 3, 5, 16'h8002 (-2), 7, with a behavioural 3-cycle adder -> exactly 3 cs_add pulses; x/y observed as (3,5), (8,-2), (6,7); one acc_valid pulse with acc_out=16'h000D.
- Operands 5 and 16'h8005 (N_TERMS=2), adder returns 16'h8000 -> acc_out=16'h0000, acc_valid pulses once.
- in_valid deasserted for 4 cycles between operands -> FSM holds in FETCH with no cs_add; final sum correct; x/y stable during every WAIT state.
- Adder stub never lowers rdy_add after cs_add -> err_timeout=1 after TIMEOUT cycles in WAIT_LO, busy=0, no acc_valid; a following start clears err_timeout.
- rst asserted during WAIT_HI -> next cycle cs_add=0, busy=0, acc_valid=0, in_ready=0; a new start then completes a fresh sum correctly.
- start pulsed while busy, and N_TERMS=1 with operand 16'h8009 -> start ignored mid-run; N_TERMS=1 gives zero cs_add pulses and acc_out=16'h8009 two cycles after the handshake.

Source files
------------

// File: rtl/sm_accum_initiator_if.sv
// Operand stream, adder handshake and result signals of the sign-magnitude accumulator.
// The accumulator sits on the master side; the operand source and the adder drive the rest.
interface sm_accum_initiator_if;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        cs_add;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] sum;
    logic        rdy_add;
    logic [15:0] acc_out;
    logic        acc_valid;
    logic        busy;
    logic        err_timeout;

    modport master (
        input  start, in_valid, in_data, sum, rdy_add,
        output in_ready, cs_add, x, y, acc_out, acc_valid, busy, err_timeout
    );

    modport slave (
        output start, in_valid, in_data, sum, rdy_add,
        input  in_ready, cs_add, x, y, acc_out, acc_valid, busy, err_timeout
    );
endinterface

// File: rtl/sm_accum_initiator.sv
// Sums N_TERMS sign-magnitude operands through an external adder reached over the
// cs_add/rdy_add handshake; the final value is reported with a one-cycle acc_valid pulse.
module sm_accum_initiator #(
    parameter int N_TERMS = 8,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    sm_accum_initiator_if.master bus
);
    localparam int                WAIT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST_TERM  = CNT_W'(N_TERMS);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);
    localparam logic [15:0]       NEG_ZERO   = 16'h8000;

    typedef enum logic [2:0] {
        IDLE, LOAD, FETCH, REQ, WAIT_LO, WAIT_HI, DONE
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_inc;
    logic [15:0]       acc;
    logic [15:0]       x_q, y_q, acc_out_q;
    logic              cs_q, acc_valid_q, err_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_expired;
    logic              in_ready;
    logic              issue;
    logic              abort;

    assign count_inc    = count + 1'b1;
    assign wait_expired = (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output of this block gets a default before the case, so no path leaves a latch.
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        issue    = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nx = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_nx = (N_TERMS == 1) ? DONE : FETCH;
            end
            FETCH: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nx = REQ;
                    issue    = bus.rdy_add;
                end
            end
            REQ: begin
                // Leave once the request has been on the wire for its single cycle.
                if (cs_q) state_nx = WAIT_LO;
                else      issue    = bus.rdy_add;
            end
            WAIT_LO: begin
                if (!bus.rdy_add) begin
                    state_nx = WAIT_HI;
                end else if (wait_expired) begin
                    state_nx = IDLE;
                    abort    = 1'b1;
                end
            end
            WAIT_HI: begin
                if (bus.rdy_add) begin
                    state_nx = (count_inc == LAST_TERM) ? DONE : FETCH;
                end else if (wait_expired) begin
                    state_nx = IDLE;
                    abort    = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            acc         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            cs_q        <= 1'b0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            err_q       <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            cs_q        <= issue;
            acc_valid_q <= (state == DONE);
            if (state_nx != state)  wait_cnt <= '0;
            else if (!wait_expired) wait_cnt <= wait_cnt + 1'b1;
            if (abort) err_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        err_q <= 1'b0;
                        count <= '0;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        acc   <= bus.in_data;
                        count <= CNT_W'(1);
                    end
                end
                FETCH: begin
                    // x/y are only written here, so they hold through REQ and both waits.
                    if (bus.in_valid) begin
                        x_q <= acc;
                        y_q <= bus.in_data;
                    end
                end
                WAIT_HI: begin
                    if (bus.rdy_add) begin
                        acc   <= bus.sum;
                        count <= count_inc;
                    end
                end
                DONE:    acc_out_q <= (acc == NEG_ZERO) ? 16'h0000 : acc;
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.cs_add      = cs_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.acc_out     = acc_out_q;
    assign bus.acc_valid   = acc_valid_q;
    assign bus.busy        = (state != IDLE);
    assign bus.err_timeout = err_q;
endmodule
